// File: rtl/arb_req_concentrator.sv
// arb_req_concentrator
//
// Front end for a round-robin arbiter. Each requester owns a small FIFO.
// The arbiter sees one request line per non-empty FIFO. The winning FIFO's
// head entry is moved into a registered valid/ready output port, tagged
// with the requester index.
//
// Ports
//   clock_i      : clock, rising edge
//   reset_i      : asynchronous reset, active high
//   req_valid_i  : per-requester request valid
//   req_data_i   : per-requester payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o  : per-requester accept (FIFO not full)
//   arb_reqs_o   : request lines to the arbiter
//   arb_grants_i : one-hot (or zero) grants from the arbiter
//   arb_pop_o    : tells the arbiter that its grant is consumed this cycle
//   out_valid_o  : output register holds a request
//   out_data_o   : granted payload
//   out_id_o     : index of the granted requester
//   out_ready_i  : downstream accept

module arb_req_concentrator #(
    parameter  int NUM_REQS   = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH = 2,
    localparam int ID_WIDTH   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [NUM_REQS-1:0]            req_valid_i,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQS-1:0]            req_ready_o,
    output logic [NUM_REQS-1:0]            arb_reqs_o,
    input  logic [NUM_REQS-1:0]            arb_grants_i,
    output logic                           arb_pop_o,
    output logic                           out_valid_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic [ID_WIDTH-1:0]            out_id_o,
    input  logic                           out_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_REQS-1:0]   full;
    logic [NUM_REQS-1:0]   empty;
    logic [NUM_REQS-1:0]   push;
    logic [NUM_REQS-1:0]   pop;
    logic [DATA_WIDTH-1:0] head [NUM_REQS];

    logic                  load_en;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

    // The output register can take a new entry when it is empty or being
    // drained this cycle. Otherwise requests are hidden from the arbiter so
    // its round-robin pointer does not move on a grant that cannot be used.
    assign load_en    = !out_valid_q || out_ready_i;
    assign arb_reqs_o = load_en ? ~empty : '0;
    assign arb_pop_o  = |arb_reqs_o;

    // Qualify with our own requests so a stray grant can never pop a FIFO.
    assign pop         = arb_grants_i & arb_reqs_o;
    assign req_ready_o = ~full;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;

        assign full[g]  = (cnt_q == CNT_W'(FIFO_DEPTH));
        assign empty[g] = (cnt_q == '0);
        assign push[g]  = req_valid_i[g] && !full[g];
        assign head[g]  = mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push[g]) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop[g]) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push[g], pop[g]})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: an entry is only read after it was written.
        always_ff @(posedge clock_i) begin
            if (push[g]) begin
                mem_q[wr_ptr_q] <= req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (load_en) begin
            // No grant while loadable means the register empties (or stays
            // empty); data and id keep their last values.
            out_valid_d = |pop;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (pop[i]) begin
                    out_data_d = head[i];
                    out_id_d   = ID_WIDTH'(i);
                end
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_id_o    = out_id_q;

`ifndef SYNTHESIS
    a_grant_onehot : assert property (@(posedge clock_i) disable iff (reset_i)
        $onehot0(arb_grants_i));
    a_grant_needs_req : assert property (@(posedge clock_i) disable iff (reset_i)
        (arb_grants_i != '0) |-> (arb_reqs_o != '0));
    a_grant_not_empty : assert property (@(posedge clock_i) disable iff (reset_i)
        ((arb_grants_i & empty) == '0));
`endif

endmodule

// File: tb/tb_arb_req_concentrator.sv
module tb_arb_req_concentrator;

    localparam int NR = 4;
    localparam int DW = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  arb_reqs;
    logic [NR-1:0]  arb_grants;
    logic           arb_pop;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic [1:0]     out_id;
    logic           out_ready;

    always #5 clock = ~clock;

    arb_req_concentrator #(.NUM_REQS(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .arb_reqs_o   (arb_reqs),
        .arb_grants_i (arb_grants),
        .arb_pop_o    (arb_pop),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_id_o     (out_id),
        .out_ready_i  (out_ready)
    );

    // Reference round-robin arbiter: highest priority starts at prio_q and
    // moves just past the winner whenever a grant is popped.
    int prio_q;

    always_comb begin
        arb_grants = '0;
        for (int k = 0; k < NR; k++) begin
            if (arb_grants == '0 && arb_reqs[(prio_q + k) % NR]) begin
                arb_grants[(prio_q + k) % NR] = 1'b1;
            end
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q <= 0;
        end else if (arb_pop) begin
            for (int k = 0; k < NR; k++) begin
                if (arb_grants[k]) prio_q <= (k + 1) % NR;
            end
        end
    end

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pop_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && arb_pop) pop_cnt++;
    end

    // Monitor: every handshake must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got id=%0d data=0x%0h expected nothing at %0t",
                         out_id, out_data, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_out_id", 32'(out_id), 32'(e.id));
                chk("sb_out_data", out_data, e.data);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_item(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        int pc0;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'hF);
        chk("rst_arb_reqs", 32'(arb_reqs), 32'd0);
        chk("rst_arb_pop", 32'(arb_pop), 32'd0);
        reset = 1'b0;
        cyc();

        // 1: single push, two-cycle latency, one arbiter pop
        pc0 = pop_cnt;
        req_valid[1] = 1'b1;
        req_data[1*DW +: DW] = 32'hA5A5_0001;
        expect_item(1, 32'hA5A5_0001);
        cyc();
        req_valid = '0;
        chk("t1_no_bypass", 32'(out_valid), 32'd0);
        cyc();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", out_data, 32'hA5A5_0001);
        chk("t1_out_id", 32'(out_id), 32'd1);
        repeat (3) cyc();
        chk("t1_pop_pulses", 32'(pop_cnt - pc0), 32'd1);

        // 2: all requesters at once, fresh arbiter pointer
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = 32'h10 + 32'(i);
            expect_item(i, 32'h10 + 32'(i));
        end
        req_valid = '1;
        cyc();
        req_valid = '0;
        cyc();
        for (int k = 0; k < NR; k++) begin
            chk("t2_valid", 32'(out_valid), 32'd1);
            chk("t2_id", 32'(out_id), 32'(k));
            cyc();
        end
        chk("t2_idle", 32'(out_valid), 32'd0);

        // 3: backpressure with a second request pending
        out_ready = 1'b0;
        req_data[0*DW +: DW] = 32'h30;
        req_data[1*DW +: DW] = 32'h31;
        expect_item(0, 32'h30);
        expect_item(1, 32'h31);
        req_valid = 4'b0011;
        cyc();
        req_valid = '0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_data", out_data, 32'h30);
            chk("t3_hold_id", 32'(out_id), 32'd0);
            chk("t3_arb_reqs", 32'(arb_reqs), 32'd0);
            chk("t3_arb_pop", 32'(arb_pop), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("t3_resume_valid", 32'(out_valid), 32'd1);
        chk("t3_resume_data", out_data, 32'h31);
        chk("t3_resume_id", 32'(out_id), 32'd1);
        repeat (2) cyc();

        // 4: fill requester 2 while the output is stalled
        out_ready = 1'b0;
        req_data[0*DW +: DW] = 32'h40;
        expect_item(0, 32'h40);
        req_valid = 4'b0001;
        cyc();
        req_valid = '0;
        cyc();
        chk("t4_occupied", 32'(out_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t4_req_ready2", 32'(req_ready[2]), (k < 2) ? 32'd1 : 32'd0);
            req_valid[2] = 1'b1;
            req_data[2*DW +: DW] = 32'h50 + 32'(k);
            if (k < 2) expect_item(2, 32'h50 + 32'(k));
            cyc();
        end
        req_valid = '0;
        chk("t4_masked", 32'(arb_reqs), 32'd0);
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("t4_drained", 32'(sb_q.size()), 32'd0);

        // 5: pointer wrap with back-to-back streaming
        for (int k = 0; k < 7; k++) begin
            chk("t5_req_ready3", 32'(req_ready[3]), 32'd1);
            req_valid[3] = 1'b1;
            req_data[3*DW +: DW] = 32'(k);
            expect_item(3, 32'(k));
            cyc();
        end
        req_valid = '0;
        repeat (4) cyc();
        chk("t5_drained", 32'(sb_q.size()), 32'd0);

        // 6: asynchronous reset with items in flight
        out_ready = 1'b0;
        req_data[0*DW +: DW] = 32'h60;
        req_data[1*DW +: DW] = 32'h61;
        req_data[2*DW +: DW] = 32'h62;
        req_valid = 4'b0111;
        cyc();
        req_data[3*DW +: DW] = 32'h63;
        req_valid = 4'b1000;
        cyc();
        req_valid = '0;
        cyc();
        chk("t6_occupied", 32'(out_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_ready", 32'(req_ready), 32'hF);
        chk("t6_async_reqs", 32'(arb_reqs), 32'd0);
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("t6_no_stale", 32'(out_valid), 32'd0);
            cyc();
        end
        chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_req_concentrator.md
Name: arb_req_concentrator

Overview:
Front-end stage that feeds the round-robin arbiter. It buffers requests from NUM_REQS requesters in per-requester FIFOs and drives the arbiter's reqs and pop inputs. It consumes the arbiter's one-hot grants and forwards the granted payload, tagged with the requester index, to a single registered output port with a valid/ready handshake. It sits between the requesters and a shared downstream resource, such as a memory or bus port.

Parameters:
NUM_REQS, 4, number of requesters (>=1); must match the arbiter instance.
DATA_WIDTH, 32, payload width per request.
FIFO_DEPTH, 2, entries per requester FIFO; power of two, >=2.
ID_WIDTH (localparam), max(1, clog2(NUM_REQS)), width of out_id.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQS  per-requester request valid.
req_data  in  NUM_REQS*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  out  NUM_REQS  per-requester accept.
arb_reqs  out  NUM_REQS  to the arbiter reqs input.
arb_grants  in  NUM_REQS  from the arbiter grants output; one-hot or zero.
arb_pop  out  1  to the arbiter pop input.
out_valid  out  1  output holds a valid request.
out_data  out  DATA_WIDTH  granted payload.
out_id  out  ID_WIDTH  index of the granted requester.
out_ready  in  1  downstream accept.

Behaviour:
- Reset (asynchronous, active-high):
  - all FIFOs empty: read/write pointers and counts = 0;
  - out_valid = 0, out_data = 0, out_id = 0;
  - as a consequence, req_ready = all ones, arb_reqs = 0, arb_pop = 0.
- Reset asserted mid-operation discards all buffered and in-flight requests. No partial output survives.
- Input side, per requester i:
  - req_ready[i] = !full[i], combinational from FIFO state only; no dependence on req_valid.
  - Push when req_valid[i] && req_ready[i]; data is written at the clock edge.
  - A push and a pop on the same FIFO in the same cycle is legal when not full; the count is unchanged.
  - No push is accepted when full, even if a pop occurs in that cycle.
- Pointers: log2(FIFO_DEPTH) bits each, wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits. full = (count == FIFO_DEPTH); empty = (count == 0).
- Output register enable: load_en = !out_valid || out_ready.
- arb_reqs[i] = !empty[i] && load_en. Requests are masked while the output is stalled, so the arbiter sees no request and does not advance its mask.
- arb_pop = |arb_reqs (combinational). The arbiter advances exactly when a grant is consumed.
- Grant consumption (combinational from arb_grants, same cycle):
  - the FIFO with arb_grants[i] = 1 pops;
  - out_data <= its head entry;
  - out_id <= i (one-hot to binary);
  - out_valid <= 1.
- If load_en = 1 and no grant is consumed: out_valid <= 0 when out_ready = 1. out_data and out_id hold their last values.
- While out_valid && !out_ready: out_valid, out_data and out_id are held stable.
- Latency: a push accepted in cycle N appears on out_valid in cycle N+2 at the earliest. There is no bypass path.
- Throughput: one request per cycle when out_ready is held at 1.
- Illegal conditions, checked by assertions (not synthesized):
  - arb_grants with more than one bit set;
  - arb_grants nonzero while arb_reqs == 0;
  - arb_grants bit set for an empty FIFO.
- Per-requester order is strictly FIFO. Cross-requester order follows the arbiter.
- NUM_REQS = 1: out_id = 0 always; the block degenerates to a FIFO plus an output register.

Test Plan:
1. Reset, then requester 1 pushes 0xA5A5_0001 in cycle 1 with out_ready = 1 -> out_valid = 1 in cycle 3, out_data = 0xA5A5_0001, out_id = 1; arb_pop pulses exactly once.
2. All four requesters push one item in the same cycle (data = 0x10+i), out_ready = 1, real arbiter connected -> outputs on consecutive cycles with out_id 0,1,2,3 and data 0x10..0x13.
3. Backpressure: out_valid = 1, out_ready = 0 for 5 cycles with requests pending -> out_data and out_id stable, arb_reqs = 0, arb_pop = 0 throughout; resumes with the next item the cycle after out_ready = 1.
4. Full FIFO: out_ready = 0 and output already occupied; requester 2 drives req_valid for 4 cycles -> 2 pushes accepted, then req_ready[2] = 0; releasing out_ready drains the items in push order.
5. Pointer wrap: requester 3 streams 7 items 0..6 back-to-back with out_ready = 1 -> outputs 0..6 in order; no loss or duplication; req_ready[3] never drops.
6. Reset mid-operation: 3 items buffered and out_valid = 1, assert reset asynchronously between edges -> out_valid = 0 immediately, all req_ready = 1; after release, no stale item is ever output.
